// File: rtl/fifo_modport.sv
// Single-clock synchronous FIFO with registered read data, count-derived flags and exported pointers.
// Define FIFO_MEM_DEBUG_EN to add the `fifo` output port that mirrors the storage array.
module fifo_modport #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_SIZE  = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Wr_enable,
    input  logic                  Read_enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH-1:0] write_ptr,
    output logic [ADDR_WIDTH-1:0] read_ptr
`ifdef FIFO_MEM_DEBUG_EN
    ,
    output logic [DATA_WIDTH-1:0] fifo [FIFO_SIZE-1:0]
`endif
);

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(FIFO_SIZE);

    logic [DATA_WIDTH-1:0] mem [FIFO_SIZE-1:0];
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   count_next;
    logic                  we_ok;
    logic                  re_ok;

    // Flags decode the registered count only, so they never depend on the enables.
    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);
    assign we_ok = Wr_enable & ~full;
    assign re_ok = Read_enable & ~empty;

`ifdef FIFO_MEM_DEBUG_EN
    assign fifo = mem;
`endif

    always_comb begin
        // NOTE: assign a default first so every path drives count_next and no latch is inferred.
        count_next = count;
        case ({we_ok, re_ok})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // NOTE: storage has no reset; its contents are don't-care until written, which keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (we_ok) begin
            mem[write_ptr] <= data_in;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            write_ptr <= '0;
            read_ptr  <= '0;
            count     <= '0;
            data_out  <= '0;
        end else begin
            count <= count_next;
            if (we_ok) begin
                write_ptr <= write_ptr + 1'b1;
            end
            if (re_ok) begin
                data_out <= mem[read_ptr];
                read_ptr <= read_ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_modport.sv
// Self-checking bench for fifo_modport: queue-based reference model compared every cycle,
// plus directed literal checks for reset, fill, drain, wrap-around and simultaneous access.
module tb_fifo_modport;

    localparam int AW    = 5;
    localparam int DW    = 8;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          Wr_enable = 1'b0;
    logic          Read_enable = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;
    logic [AW-1:0] write_ptr;
    logic [AW-1:0] read_ptr;
`ifdef FIFO_MEM_DEBUG_EN
    logic [DW-1:0] fifo_mirror [DEPTH-1:0];
`endif

    int n_checks = 0;
    int n_fail   = 0;

    fifo_modport #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .Wr_enable   (Wr_enable),
        .Read_enable (Read_enable),
        .data_in     (data_in),
        .data_out    (data_out),
        .full        (full),
        .empty       (empty),
        .write_ptr   (write_ptr),
        .read_ptr    (read_ptr)
`ifdef FIFO_MEM_DEBUG_EN
        ,
        .fifo        (fifo_mirror)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of stored words plus pointer positions kept modulo the depth.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout = '0;
    int            m_wp = 0;
    int            m_rp = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            m_dout = '0;
            m_wp   = 0;
            m_rp   = 0;
        end else begin
            bit do_wr, do_rd;
            do_wr = Wr_enable && (q.size() < DEPTH);
            do_rd = Read_enable && (q.size() > 0);
            if (do_rd) begin
                m_dout = q.pop_front();
                m_rp   = (m_rp + 1) % DEPTH;
            end
            if (do_wr) begin
                q.push_back(data_in);
                m_wp = (m_wp + 1) % DEPTH;
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            check("data_out", 32'(data_out), 32'(m_dout));
            check("full", 32'(full), 32'(q.size() == DEPTH));
            check("empty", 32'(empty), 32'(q.size() == 0));
            check("write_ptr", 32'(write_ptr), 32'(m_wp));
            check("read_ptr", 32'(read_ptr), 32'(m_rp));
        end
    end

    // Drive one cycle of inputs, wait for the edge, then release the enables shortly after it.
    task automatic step(input logic we, input logic re, input logic [DW-1:0] d);
        Wr_enable   = we;
        Read_enable = re;
        data_in     = d;
        @(posedge clk);
        #1;
        Wr_enable   = 1'b0;
        Read_enable = 1'b0;
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b0;
        #1;
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_wptr", 32'(write_ptr), 32'd0);
        check("rst_rptr", 32'(read_ptr), 32'd0);
        check("rst_dout", 32'(data_out), 32'd0);
        @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Power-on reset
        #2 reset = 1'b0;
        #1;
        check("por_empty", 32'(empty), 32'd1);
        check("por_full", 32'(full), 32'd0);
        check("por_dout", 32'(data_out), 32'd0);
        #10 reset = 1'b1;
        @(posedge clk);
        #1;

        // Reset mid-stream after 5 writes; the next read must return the first post-reset word
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'(8'h10 + i));
        pulse_reset();
        step(1'b1, 1'b0, 8'hAA);
        step(1'b0, 1'b1, 8'h00);
        check("post_rst_read", 32'(data_out), 32'h0000_00AA);

        // Fill from a clean state
        pulse_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'(i));
        check("fill_full", 32'(full), 32'd1);
        check("fill_wptr_wrap", 32'(write_ptr), 32'd0);
        step(1'b1, 1'b0, 8'hFF);
        check("ovf_wptr", 32'(write_ptr), 32'd0);
        check("ovf_full", 32'(full), 32'd1);

        // Drain in order, then one ignored read
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, 8'h00);
            check("drain_data", 32'(data_out), 32'(i));
        end
        check("drain_empty", 32'(empty), 32'd1);
        step(1'b0, 1'b1, 8'h00);
        check("udf_dout", 32'(data_out), 32'h0000_001F);
        check("udf_rptr", 32'(read_ptr), 32'd0);

        // Wrap-around
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, DW'(8'h20 + i));
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, DW'(8'h40 + i));
        check("wrap_wptr", 32'(write_ptr), 32'd8);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 8'h00);
            check("wrap_data", 32'(data_out), 32'(8'h40 + i));
        end
        check("wrap_rptr", 32'(read_ptr), 32'd8);

        // Simultaneous access with 3 entries: order kept, occupancy constant
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DW'(8'h60 + i));
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, DW'(8'h63 + i));
            check("sim_data", 32'(data_out), 32'(8'h60 + i));
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00);
        check("sim_drained_last", 32'(data_out), 32'h0000_006C);
        check("sim_drained_empty", 32'(empty), 32'd1);

        // Both asserted while empty: only the write lands
        step(1'b1, 1'b1, 8'h77);
        check("empty_both_empty", 32'(empty), 32'd0);
        check("empty_both_dout", 32'(data_out), 32'h0000_006C);

        // Both asserted while full: only the read lands
        for (int i = 1; i < DEPTH; i++) step(1'b1, 1'b0, DW'(8'h80 + i));
        check("full_before", 32'(full), 32'd1);
        step(1'b1, 1'b1, 8'hEE);
        check("full_both_full", 32'(full), 32'd0);
        check("full_both_dout", 32'(data_out), 32'h0000_0077);

        // Random traffic with the write/read bias varied so both boundaries are visited
        for (int blk = 0; blk < 4; blk++) begin
            for (int i = 0; i < 500; i++) begin
                int r;
                logic we, re;
                r  = int'($urandom_range(0, 99));
                we = (r < ((blk % 2 == 0) ? 70 : 30));
                re = (int'($urandom_range(0, 99)) < ((blk % 2 == 0) ? 30 : 70));
                step(we, re, DW'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
